btn_ctrl: RTL and testbench

Button front-end controller for the cursor `move` datapath. It synchronises and debounces the five raw board keys and arbitrates between simultaneous presses. It emits single-cycle direction commands on the `BUTTON_*` code bus that `move` consumes, with optional auto-repeat while a direction is held. The centre key is delivered separately as a one-cycle select pulse to the game FSM. It sits between the board pins and `move`.

---
 rtl/btn_ctrl.sv | 165 ++++++++++++++++
 tb/tb_btn_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_ctrl.sv
// Button front end: 2-flop sync, per-key debounce, up>down>left>right arbitration,
// one-cycle direction codes and centre select pulse. Auto-repeat built only when BTN_AUTOREPEAT_EN is defined.
module btn_ctrl #(
    parameter logic [19:0] DEB_CYCLES    = 20'd500000,
    parameter logic [25:0] REPEAT_DELAY  = 26'd25000000,
    parameter logic [25:0] REPEAT_PERIOD = 26'd10000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] key_i,
    output logic [4:0] button_o,
    output logic       select_o,
    output logic       busy_o
);

    localparam logic [4:0] BUTTON_NONE  = 5'b00000;
    localparam logic [4:0] BUTTON_UP    = 5'b00001;
    localparam logic [4:0] BUTTON_DOWN  = 5'b00010;
    localparam logic [4:0] BUTTON_LEFT  = 5'b00100;
    localparam logic [4:0] BUTTON_RIGHT = 5'b01000;

    typedef enum logic [1:0] {
        IDLE,
        HOLD
`ifdef BTN_AUTOREPEAT_EN
        , REPEAT
`endif
    } state_t;

    logic [4:0]  sync_1, sync_2;
    logic [1:0]  sync_vld;
    logic [4:0]  deb, deb_q, armed, rise;
    logic [19:0] deb_cnt [5];
    logic [1:0]  pick, active;
    logic        pick_vld;
    state_t      state;
`ifdef BTN_AUTOREPEAT_EN
    logic [25:0] rpt_cnt;
`endif

    function automatic logic [4:0] dir_code(input logic [1:0] k);
        case (k)
            2'd0:    return BUTTON_UP;
            2'd1:    return BUTTON_DOWN;
            2'd2:    return BUTTON_LEFT;
            default: return BUTTON_RIGHT;
        endcase
    endfunction

    // sync_vld marks when sync_2 holds a real key sample rather than its reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1   <= '0;
            sync_2   <= '0;
            sync_vld <= '0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge value, which is what makes this a two-stage chain.
            sync_1   <= key_i;
            sync_2   <= sync_1;
            sync_vld <= {sync_vld[0], 1'b1};
        end
    end

    // A key is armed once it is seen released after reset, so a key held through reset never fires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the debounce counters are a handful of flops, not RAM, so resetting the array is cheap and required.
            for (int k = 0; k < 5; k++) deb_cnt[k] <= '0;
            deb   <= '0;
            deb_q <= '0;
            armed <= '0;
        end else begin
            for (int k = 0; k < 5; k++) begin
                if (sync_2[k] != deb[k]) begin
                    if (deb_cnt[k] == DEB_CYCLES) begin
                        deb[k]     <= ~deb[k];
                        deb_cnt[k] <= '0;
                    end else begin
                        deb_cnt[k] <= deb_cnt[k] + 20'd1;
                    end
                end else begin
                    deb_cnt[k] <= '0;
                end
                if (sync_vld[1] && !sync_2[k]) armed[k] <= 1'b1;
            end
            deb_q <= deb;
        end
    end

    assign rise = deb & ~deb_q & armed;

    always_comb begin
        // NOTE: every path assigns pick, so no latch is inferred.
        pick_vld = |rise[3:0];
        if (rise[0])      pick = 2'd0;
        else if (rise[1]) pick = 2'd1;
        else if (rise[2]) pick = 2'd2;
        else              pick = 2'd3;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            active   <= '0;
            button_o <= BUTTON_NONE;
            busy_o   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rpt_cnt  <= '0;
`endif
        end else begin
            button_o <= BUTTON_NONE;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        active   <= pick;
                        button_o <= dir_code(pick);
                        busy_o   <= 1'b1;
                        state    <= HOLD;
`ifdef BTN_AUTOREPEAT_EN
                        rpt_cnt  <= '0;
`endif
                    end
                end
                HOLD: begin
                    if (!deb[active]) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
`ifdef BTN_AUTOREPEAT_EN
                    else if (rpt_cnt == REPEAT_DELAY - 26'd1) begin
                        button_o <= dir_code(active);
                        rpt_cnt  <= '0;
                        state    <= REPEAT;
                    end else begin
                        rpt_cnt <= rpt_cnt + 26'd1;
                    end
`endif
                end
`ifdef BTN_AUTOREPEAT_EN
                REPEAT: begin
                    if (!deb[active]) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else if (rpt_cnt == REPEAT_PERIOD - 26'd1) begin
                        button_o <= dir_code(active);
                        rpt_cnt  <= '0;
                    end else begin
                        rpt_cnt <= rpt_cnt + 26'd1;
                    end
                end
`endif
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) select_o <= 1'b0;
        else     select_o <= rise[4];
    end

endmodule

// File: tb/tb_btn_ctrl.sv
// Bench for btn_ctrl: directed scenarios plus random key patterns, checked every cycle
// against a cycle-level reference model of sampling, debouncing and command scheduling.
module tb_btn_ctrl;

    localparam int DEB     = 4;
    localparam int RDELAY  = 20;
    localparam int RPERIOD = 8;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    localparam logic [4:0] K_UP = 5'b00001, K_DOWN = 5'b00010, K_LEFT = 5'b00100,
                           K_RIGHT = 5'b01000, K_CENTRE = 5'b10000;
    localparam logic [4:0] B_NONE = 5'b00000;
    logic [4:0] dir_codes [4] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst_req = 1'b1;
    logic [4:0] key_i = '0;
    logic [4:0] button_o;
    logic       select_o;
    logic       busy_o;

    btn_ctrl #(
        .DEB_CYCLES   (20'(DEB)),
        .REPEAT_DELAY (26'(RDELAY)),
        .REPEAT_PERIOD(26'(RPERIOD))
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .key_i   (key_i),
        .button_o(button_o),
        .select_o(select_o),
        .busy_o  (busy_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int pc [4];
    int n_sel;
    int first_up;

    // Reference model: raw-key delay line, run-length debounce, and a command scheduler
    // that tracks cycles since the last command against the next due interval.
    logic [4:0] m_s1, m_s2, m_lvl, m_lvl_prev, m_armed;
    int         m_vld;
    int         m_run [5];
    int         m_active;
    int         m_since;
    bit         m_repeated;
    logic [4:0] m_button;
    bit         m_select, m_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h, want %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_lvl_prev = '0; m_armed = '0; m_vld = 0;
        for (int k = 0; k < 5; k++) m_run[k] = 0;
        m_active = -1; m_since = 0; m_repeated = 1'b0;
        m_button = B_NONE; m_select = 1'b0; m_busy = 1'b0;
    endtask

    task automatic model_edge(input logic [4:0] k);
        logic [4:0] fresh;
        int pick;
        fresh    = m_lvl & ~m_lvl_prev & m_armed;
        m_select = fresh[4];
        m_button = B_NONE;
        if (m_active < 0) begin
            pick = -1;
            for (int j = 0; j < 4; j++) if (pick < 0 && fresh[j]) pick = j;
            if (pick >= 0) begin
                m_active = pick; m_button = dir_codes[pick];
                m_since = 0; m_repeated = 1'b0;
            end
        end else if (!m_lvl[m_active]) begin
            m_active = -1;
        end else begin
            m_since++;
            if (AUTO && m_since == (m_repeated ? RPERIOD : RDELAY)) begin
                m_button = dir_codes[m_active]; m_since = 0; m_repeated = 1'b1;
            end
        end
        m_busy     = (m_active >= 0);
        m_lvl_prev = m_lvl;
        for (int j = 0; j < 5; j++) begin
            if (m_s2[j] != m_lvl[j]) begin
                m_run[j]++;
                if (m_run[j] > DEB) begin m_lvl[j] = ~m_lvl[j]; m_run[j] = 0; end
            end else begin
                m_run[j] = 0;
            end
            if (m_vld >= 2 && !m_s2[j]) m_armed[j] = 1'b1;
        end
        m_vld = (m_vld < 2) ? m_vld + 1 : 2;
        m_s2  = m_s1;
        m_s1  = k;
    endtask

    task automatic compare_outputs();
        check("button", 32'(button_o), 32'(m_button));
        check("select", 32'(select_o), 32'(m_select));
        check("busy",   32'(busy_o),   32'(m_busy));
    endtask

    task automatic step(input logic [4:0] k);
        @(negedge clk);
        key_i = k;
        rst   = rst_req;
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge(k);
        #1;
        cyc++;
        compare_outputs();
        for (int j = 0; j < 4; j++) if (button_o === dir_codes[j]) pc[j]++;
        if (button_o === K_UP && first_up < 0) first_up = cyc;
        if (select_o === 1'b1) n_sel++;
    endtask

    task automatic hold(input logic [4:0] k, input int n);
        repeat (n) step(k);
    endtask

    task automatic clear_counts();
        for (int j = 0; j < 4; j++) pc[j] = 0;
        n_sel = 0;
        first_up = -1;
    endtask

    // Async assertion between edges: outputs must clear without waiting for a clock.
    task automatic async_reset(input string tag);
        rst_req = 1'b1;
        rst = 1'b1;
        #1;
        model_reset();
        check({tag, "_button"}, 32'(button_o), 32'(B_NONE));
        check({tag, "_select"}, 32'(select_o), 32'(1'b0));
        check({tag, "_busy"},   32'(busy_o),   32'(1'b0));
    endtask

    initial begin
        int press;
        logic [4:0] k;
        model_reset();
        clear_counts();
        #2;
        check("rst_button", 32'(button_o), 32'(B_NONE));
        check("rst_select", 32'(select_o), 32'(1'b0));
        check("rst_busy",   32'(busy_o),   32'(1'b0));
        hold('0, 2);
        rst_req = 1'b0;
        hold('0, 6);

        // Reset in the middle of a right-key hold.
        clear_counts();
        hold(K_RIGHT, 15);
        check("right_before_rst", 32'(pc[3]), 32'd1);
        async_reset("midhold");
        hold(K_RIGHT, 2);
        rst_req = 1'b0;
        clear_counts();
        hold(K_RIGHT, 20);
        check("right_held_thru_rst", 32'(pc[3]), 32'd0);
        hold('0, 15);
        hold(K_RIGHT, 15);
        check("right_repress", 32'(pc[3]), 32'd1);
        hold('0, 15);

        // Clean up press with latency measurement.
        clear_counts();
        press = cyc + 1;
        hold(K_UP, 10);
        hold('0, 15);
        check("up_pulses", 32'(pc[0]), 32'd1);
        check("up_latency", 32'(first_up - press), 32'd7);
        check("up_busy_after", 32'(busy_o), 32'd0);

        // Short glitches on the down key.
        clear_counts();
        repeat (20) begin
            hold(K_DOWN, $urandom_range(1, 3));
            hold('0, $urandom_range(1, 3));
        end
        hold('0, 15);
        check("glitch_down", 32'(pc[1]), 32'd0);

        // Left held 50 cycles.
        clear_counts();
        hold(K_LEFT, 50);
        hold('0, 20);
        check("left_pulses", 32'(pc[2]), AUTO ? 32'd5 : 32'd1);

        // Down and right rising together; right is held past down's release.
        clear_counts();
        hold(K_DOWN | K_RIGHT, 30);
        hold(K_RIGHT, 30);
        check("dr_down", 32'(pc[1]), AUTO ? 32'd3 : 32'd1);
        check("dr_right_lost", 32'(pc[3]), 32'd0);
        hold('0, 15);
        hold(K_RIGHT, 15);
        check("dr_right_repress", 32'(pc[3]), 32'd1);
        hold('0, 15);

        // Centre pressed while up is held.
        clear_counts();
        hold(K_UP, 10);
        hold(K_UP | K_CENTRE, 8);
        hold(K_UP, 22);
        hold('0, 20);
        check("centre_select", 32'(n_sel), 32'd1);
        check("centre_up", 32'(pc[0]), AUTO ? 32'd4 : 32'd1);

        // Random key patterns with occasional asynchronous resets.
        repeat (150) begin
            k = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 2) == 0) k = '0;
            hold(k, $urandom_range(1, 25));
            if ($urandom_range(0, 19) == 0) begin
                async_reset("rand_rst");
                hold(k, 2);
                rst_req = 1'b0;
            end
        end
        hold('0, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
